// File: rtl/compose_pipe.sv
// Parametrised DEPTH-stage register pipeline with optional per-stage inversion,
// stall, flush, per-stage valid tracking, occupancy count and a runtime tap.
module compose_pipe #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 4,
  parameter bit INVERT = 1'b1,
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap,
  output logic             tap_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_s [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_count;
  logic             w_v_in;
  logic [WIDTH-1:0] w_tap;
  logic             w_tap_valid;

  // A flushing cycle drops the incoming valid along with everything in flight.
  assign w_v_in = d_valid & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_s[i] <= '0;
      end
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (en) begin
        r_s[0] <= INVERT ? ~d : d;
        r_v[0] <= w_v_in;
        for (int i = 1; i < DEPTH; i++) begin
          r_s[i] <= INVERT ? ~r_s[i-1] : r_s[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
      if (flush) begin
        r_v     <= '0;
        r_count <= '0;
      end else if (en) begin
        r_count <= r_count + CW'(w_v_in) - CW'(r_v[DEPTH-1]);
      end
    end
  end

  // Out-of-range sel falls through to the default: the last stage.
  always_comb begin
    w_tap       = r_s[DEPTH-1];
    w_tap_valid = r_v[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(sel) == i) begin
        w_tap       = r_s[i];
        w_tap_valid = r_v[i];
      end
    end
  end

  assign q         = r_s[DEPTH-1];
  assign q_valid   = r_v[DEPTH-1];
  assign tap       = w_tap;
  assign tap_valid = w_tap_valid;
  assign count     = r_count;

endmodule
